// File: rtl/meter_pkg.sv
// Shared constants, state encoding and status-byte layout for the meter framer.
package meter_pkg;

    localparam logic [7:0]  FRAME_HEADER    = 8'hA5;
    localparam int unsigned FRAME_LEN_BASE  = 14;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned SNAP_W          = 8 + 3 * DATA_W;

    localparam int unsigned STATUS_MODE_LSB = 0;
    localparam int unsigned STATUS_MODE_W   = 2;
    localparam int unsigned STATUS_HF_BIT   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] status_byte(input logic [1:0] mode, input logic hf);
        logic [7:0] s;
        s = '0;
        s[STATUS_MODE_LSB +: STATUS_MODE_W] = mode;
        s[STATUS_HF_BIT] = hf;
        return s;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// A load presented during the last stop-bit cycle chains the next byte with no gap.
module uart_byte_tx
    import meter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset_sig,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done_c
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              baud_end;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        byte_done_c = 1'b0;
        baud_end    = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    shift_d = data;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    byte_done_c = 1'b1;
                    baud_d      = '0;
                    if (load) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        shift_d = data;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_sig) begin
        if (!reset_sig) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/meter_frame_tx.sv
// Meter result framer: snapshots the measurement on request and sends it as one UART packet.
// Optional trailing checksum byte enabled by defining METER_FRAME_CHECKSUM_EN.
module meter_frame_tx
    import meter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        clk,
    input  logic        reset_sig,
    input  logic        send_req,
    input  logic [31:0] first_data,
    input  logic [31:0] second_data,
    input  logic [31:0] third_data,
    input  logic [1:0]  mode,
    input  logic        high_frequency,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
`ifdef METER_FRAME_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE + 1;
`else
    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept_c;
    logic              byte_done_c;
    logic              more_c;
    logic              load_c;
    logic [7:0]        byte_c;
    logic [SNAP_W-1:0] snap_sh;

    // Sequencing: byte 0 is the constant header so it can load on the accept edge itself.
    always_comb begin
        accept_c = send_req && !busy_q;
        more_c   = (idx_q != IDX_LAST);
        load_c   = accept_c || (byte_done_c && more_c);

        snap_d = snap_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        done_d = byte_done_c && !more_c;

        if (accept_c) begin
            snap_d = {status_byte(mode, high_frequency), first_data, second_data, third_data};
            idx_d  = '0;
            busy_d = 1'b1;
        end else if (byte_done_c && more_c) begin
            idx_d = idx_q + 4'd1;
        end else if (done_d) begin
            busy_d = 1'b0;
        end
    end

`ifdef METER_FRAME_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Checksum covers status plus the 12 data bytes, computed from the inputs at accept.
    always_comb begin
        csum_d = csum_q;
        if (accept_c) begin
            csum_d = status_byte(mode, high_frequency);
            for (int i = 0; i < 4; i++) begin
                csum_d = csum_d + first_data[8*i +: 8] + second_data[8*i +: 8]
                                + third_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_sig) begin
        if (!reset_sig) csum_q <= '0;
        else            csum_q <= csum_d;
    end
`endif

    // Byte mux: snapshot is stored in transmit order, so byte k sits k-1 bytes below the top.
    always_comb begin
        snap_sh = snap_q << {idx_d - 4'd1, 3'b000};
        if (idx_d == '0) begin
            byte_c = FRAME_HEADER;
`ifdef METER_FRAME_CHECKSUM_EN
        end else if (idx_d == IDX_LAST) begin
            byte_c = csum_q;
`endif
        end else begin
            byte_c = snap_sh[SNAP_W-1 -: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_sig) begin
        if (!reset_sig) begin
            snap_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            snap_q <= snap_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk         (clk),
        .reset_sig   (reset_sig),
        .load        (load_c),
        .data        (byte_c),
        .tx          (tx),
        .byte_done_c (byte_done_c)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_meter_frame_tx.sv
// Bench for meter_frame_tx: table of frames plus corner sequences, UART decoder vs expected-byte queue.
module tb_meter_frame_tx;

    localparam int unsigned CPB = 4;
`ifdef METER_FRAME_CHECKSUM_EN
    localparam int unsigned LEN = 15;
`else
    localparam int unsigned LEN = 14;
`endif
    localparam int unsigned FRAME_CYC = LEN * 10 * CPB;

    typedef struct {
        logic [31:0] f;
        logic [31:0] s;
        logic [31:0] t;
        logic [1:0]  mode;
        logic        hf;
        logic [7:0]  status;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_sig;
    logic        send_req;
    logic [31:0] first_data, second_data, third_data;
    logic [1:0]  mode;
    logic        high_frequency;
    logic        tx, busy, done;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    bit          abort_byte = 1'b0;
    vec_t        vecs[4];

    meter_frame_tx #(.CLK_HZ(400), .BAUD(100)) dut (
        .clk            (clk),
        .reset_sig      (reset_sig),
        .send_req       (send_req),
        .first_data     (first_data),
        .second_data    (second_data),
        .third_data     (third_data),
        .mode           (mode),
        .high_frequency (high_frequency),
        .tx             (tx),
        .busy           (busy),
        .done           (done)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input vec_t v);
        logic [95:0] d;
        logic [7:0]  b;
`ifdef METER_FRAME_CHECKSUM_EN
        logic [7:0]  sum;
        sum = v.status;
`endif
        d = {v.f, v.s, v.t};
        exp_q.push_back(8'hA5);
        exp_q.push_back(v.status);
        for (int i = 0; i < 12; i++) begin
            b = d[95 - 8*i -: 8];
            exp_q.push_back(b);
`ifdef METER_FRAME_CHECKSUM_EN
            sum = sum + b;
`endif
        end
`ifdef METER_FRAME_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    task automatic drive_inputs(input vec_t v);
        first_data     = v.f;
        second_data    = v.s;
        third_data     = v.t;
        mode           = v.mode;
        high_frequency = v.hf;
    endtask

    // Called at a negedge; returns the cycle number of the accepting edge.
    task automatic send_frame(input vec_t v, input bit corrupt, output int acc);
        drive_inputs(v);
        send_req = 1'b1;
        push_frame(v);
        @(negedge clk);
        send_req = 1'b0;
        acc = cyc;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_tx", 32'(tx), 32'd0);
        if (corrupt) begin
            first_data     = '1;
            second_data    = '1;
            third_data     = '1;
            mode           = 2'b11;
            high_frequency = ~v.hf;
        end
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic finish_frame(input int acc);
        int at;
        wait_done(2 * FRAME_CYC, at);
        check("done_latency", 32'(at - acc), 32'(FRAME_CYC));
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    // UART decoder: samples mid-bit on negedges and scores each byte against the queue.
    initial begin : monitor
        logic [7:0] b;
        logic       start_bad, stop_bad;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && reset_sig === 1'b1) begin
                repeat (2) @(negedge clk);
                start_bad = (tx !== 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                stop_bad = (tx !== 1'b1);
                @(negedge clk);
                if (abort_byte) begin
                    exp_q.delete();
                    abort_byte = 1'b0;
                end else if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(b), 32'h100);
                end else begin
                    check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                    check("rx_framing", 32'({start_bad, stop_bad}), 32'd0);
                end
            end
        end
    end

    initial begin : stim
        int  acc, acc2, at;
        bit  ok;

        vecs[0] = '{32'h0000_1234, 32'h0, 32'h0, 2'b10, 1'b0, 8'h02};
        vecs[1] = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 2'b11, 1'b1, 8'h13};
        vecs[2] = '{32'hDEAD_BEEF, 32'h8000_0001, 32'h7F7F_7F7F, 2'b01, 1'b0, 8'h01};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 8'h10};

        reset_sig = 1'b0;
        send_req  = 1'b0;
        drive_inputs(vecs[0]);
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset_sig = 1'b1;
        repeat (3) @(negedge clk);

        // Table: every frame also has its inputs overwritten right after accept.
        for (int k = 0; k < 4; k++) begin
            send_frame(vecs[k], 1'b1, acc);
            finish_frame(acc);
            repeat (5) @(negedge clk);
        end
        check("queue_after_table", 32'(exp_q.size()), 32'd0);

        // Request while busy is dropped.
        send_frame(vecs[2], 1'b0, acc);
        repeat (99) @(negedge clk);
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        finish_frame(acc);
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
        end
        check("busy_reject_idle", 32'(ok), 32'd1);

        // Held request: one idle cycle between frames.
        drive_inputs(vecs[1]);
        send_req = 1'b1;
        push_frame(vecs[1]);
        push_frame(vecs[1]);
        @(negedge clk);
        acc = cyc;
        wait_done(2 * FRAME_CYC, at);
        check("b2b_first_latency", 32'(at - acc), 32'(FRAME_CYC));
        check("b2b_gap_busy", 32'(busy), 32'd0);
        check("b2b_gap_tx", 32'(tx), 32'd1);
        @(negedge clk);
        acc2 = cyc;
        check("b2b_restart_tx", 32'(tx), 32'd0);
        check("b2b_restart_busy", 32'(busy), 32'd1);
        check("b2b_restart_cycle", 32'(acc2 - at), 32'd1);
        send_req = 1'b0;
        finish_frame(acc2);
        repeat (5) @(negedge clk);

        // Reset during byte 5 aborts the frame.
        send_frame(vecs[1], 1'b0, acc);
        while (cyc < acc + 5 * 10 * CPB + 10) @(negedge clk);
        abort_byte = 1'b1;
        reset_sig  = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 5) reset_sig = 1'b1;
            if (done !== 1'b0 || tx !== 1'b1) ok = 1'b0;
        end
        check("abort_no_done", 32'(ok), 32'd1);
        check("abort_queue_flushed", 32'(exp_q.size()), 32'd0);
        send_frame(vecs[3], 1'b0, acc);
        finish_frame(acc);

        repeat (10) @(negedge clk);
        check("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/meter_frame_tx.md
# meter_frame_tx

Serial framer downstream of the frequency meter's result selector. It snapshots the three 32-bit measurement words, the 2-bit input mode and the high-frequency flag on a send request. It then transmits them as one fixed-length packet on an 8N1 UART line to the host. One frame is in flight at a time, and requests are not queued.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division, must be ≥ 2).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_sig`  in  1  reset, asynchronous, active-low.
- `send_req`  in  1  start request; sampled each cycle, accepted only when `busy`=0.
- `first_data`  in  32  word 0 of the packet.
- `second_data`  in  32  word 1 of the packet.
- `third_data`  in  32  word 2 of the packet.
- `mode`  in  2  input-presence code (bit1 = sig1 seen, bit0 = sig2 seen).
- `high_frequency`  in  1  gate-period measurement selected.
- `tx`  out  1  UART line, idle high.
- `busy`  out  1  frame accepted and not yet finished.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- Frame byte order:
  - `0xA5` header.
  - Status byte `{3'b000, high_frequency, 2'b00, mode}`.
  - `first_data`, then `second_data`, then `third_data`, each big-endian (MSB byte first).
  - Optional checksum (see Configuration).
- Frame length is 14 bytes, or 15 with checksum.
- Each byte is sent as start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Accept: on a cycle with `send_req`=1 and `busy`=0, all inputs are registered into a 104-bit snapshot. Input changes after accept never affect the frame in flight.
- States:
  - IDLE: `tx`=1. Moves to START on accept.
  - START: moves to DATA after one bit time.
  - DATA: moves to STOP after 8 bit times.
  - STOP: after one bit time, moves to START if more bytes remain, otherwise to IDLE with `done`.
- A byte index counter runs 0..13 (or 0..14) and selects the byte from the snapshot. A bit counter runs 0..7. A baud counter runs 0..CLKS_PER_BIT-1 and wraps.
- `send_req` while `busy`=1 is ignored and not remembered.
- `send_req` held high re-triggers: the first cycle with `busy`=0 accepts again. There are no idle gaps beyond that one cycle.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0. All counters are 0, state is IDLE, snapshot is 0.
- Reset asserted mid-frame aborts immediately and asynchronously: `tx` returns to 1 and `busy` to 0. No `done` is produced.
- Accept at cycle edge N gives `busy`=1 and `tx`=0 (start bit) from cycle N+1.
- Byte k's start bit begins at N+1+k·10·CLKS_PER_BIT.
- Frame duration is L·10·CLKS_PER_BIT cycles, where L is the frame length in bytes.
- `done`=1 for exactly the one cycle in which the last stop bit ends. `busy` falls on that same edge.
- A new accept is possible in the cycle after `done`.

## Configuration
- `METER_FRAME_CHECKSUM_EN` defined: a 15th byte is appended. It is the 8-bit modular sum of the status byte and the 12 data bytes. The header is excluded.
- Macro undefined: the frame is 14 bytes, and no checksum adder or register is synthesized.

## Structure
- Shared package `meter_pkg` holds:
  - the `FRAME_HEADER` = 8'hA5 constant;
  - `FRAME_LEN_BASE` = 14;
  - the state enum (IDLE, START, DATA, STOP);
  - the status-byte field positions.
- Sub-module `uart_byte_tx` is a natural split. It owns the baud counter, the bit counter and the start/data/stop sequencing for one byte, with a `load`/`byte_done` handshake.
- The top level owns the snapshot, the byte index, the byte mux and the checksum.

## Test plan
- Use `CLK_HZ`=400, `BAUD`=100, giving `CLKS_PER_BIT`=4 in all scenarios.
- Basic frame, no checksum:
  - Stimulus: first=0x00001234, second=0, third=0, mode=2'b10, high_frequency=0, one-cycle `send_req`.
  - Response: bytes A5 02 00 00 12 34 followed by 8×00, decoded LSB-first.
  - Response: `done` at exactly 14·40 = 560 cycles after accept.
- Checksum build:
  - Stimulus: first=0x01020304, second=0x05060708, third=0x090A0B0C, mode=2'b11, high_frequency=1.
  - Response: status 0x13, checksum 0x13+0x4E = 0x61, 15 bytes in total.
- Snapshot isolation:
  - Stimulus: change all data inputs to 0xFFFFFFFF one cycle after accept.
  - Response: the transmitted payload is still the pre-accept values.
- Busy rejection:
  - Stimulus: pulse `send_req` at cycle 100 of a frame.
  - Response: no second frame follows. `tx` stays 1 after `done`.
- Back-to-back:
  - Stimulus: hold `send_req`=1.
  - Response: the second header start bit begins 1 cycle after `done`.
- Reset mid-frame:
  - Stimulus: drop `reset_sig` during byte 5.
  - Response: `tx`=1 and `busy`=0 immediately with no `done`. After release, a fresh request sends a complete frame starting with A5.
